// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction-memory loader with CPU fetch hold
//
// Assembles little-endian bytes from a valid/ready byte source into 32-bit
// instruction words and writes them to consecutive instruction-memory word
// addresses starting at 0. The CPU is held while a session is in progress.
//
// Ports:
//   clk, rst_n        single clock, synchronous active-low reset
//   start             one-cycle session request (honoured in IDLE only)
//   word_count[12:0]  words to load, saturated to MAX_WORDS, sampled on start
//   byte_valid        source presents byte_data
//   byte_data[7:0]    byte payload
//   byte_ready        loader accepts a byte this cycle
//   imem_we           one-cycle instruction-memory write strobe
//   imem_addr         word address of the current/last write
//   imem_wdata[31:0]  word of the current/last write
//   busy, cpu_hold    session in progress (identical)
//   done              one-cycle pulse at session end

module imem_loader #(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [12:0]       word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [12:0] MAX_CNT = 13'(MAX_WORDS);

    state_t            state;
    state_t            state_nxt;

    logic [12:0]       count_q;      // saturated session length
    logic [12:0]       written_q;    // words written so far this session
    logic [ADDR_W-1:0] addr_q;       // address of the word being collected
    logic [1:0]        byte_idx_q;
    logic [23:0]       lo_bytes_q;   // bytes 0..2 of the word in progress
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] imem_addr_q;

    logic              accept;
    logic              last_byte;
    logic              last_word;
    logic [12:0]       start_count;

    assign accept      = (state == COLLECT) && byte_valid;
    assign last_byte   = accept && (byte_idx_q == 2'd3);
    assign last_word   = ((written_q + 13'd1) == count_q);
    assign start_count = (word_count > MAX_CNT) ? MAX_CNT : word_count;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (start_count == 13'd0) ? FINISH : COLLECT;
                end
            end
            COLLECT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (last_byte) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                imem_we   = 1'b1;
                busy      = 1'b1;
                state_nxt = last_word ? FINISH : COLLECT;
            end
            FINISH: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: counters, byte assembly and the registered write port.
    // The write address/data are captured together with the fourth byte so
    // that they are stable during WRITE and keep their value afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q     <= 13'd0;
            written_q   <= 13'd0;
            addr_q      <= '0;
            byte_idx_q  <= 2'd0;
            lo_bytes_q  <= 24'd0;
            wdata_q     <= 32'd0;
            imem_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count_q    <= start_count;
                        written_q  <= 13'd0;
                        addr_q     <= '0;
                        byte_idx_q <= 2'd0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: lo_bytes_q[7:0]   <= byte_data;
                            2'd1: lo_bytes_q[15:8]  <= byte_data;
                            2'd2: lo_bytes_q[23:16] <= byte_data;
                            default: begin
                                wdata_q     <= {byte_data, lo_bytes_q};
                                imem_addr_q <= addr_q;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    written_q <= written_q + 13'd1;
                    // The final word leaves the address at its last value so it
                    // never steps past MAX_WORDS-1; the next start clears it.
                    if (!last_word) begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_addr  = imem_addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = busy;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, instruction-memory word-address width (4096 words).
REQ-002 SHALL have parameter MAX_WORDS, default 4096, maximum words per load session.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load session.
REQ-006 SHALL have port word_count  input  13  number of 32-bit words to load; sampled when start is accepted.
REQ-007 SHALL have port byte_valid  input  1  source presents a byte.
REQ-008 SHALL have port byte_data  input  8  byte payload.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-011 SHALL have port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-012 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-013 SHALL have port busy  output  1  load session in progress.
REQ-014 SHALL have port cpu_hold  output  1  holds CPU fetch stalled while loading.
REQ-015 SHALL have port done  output  1  one-cycle pulse at session end.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, WRITE, FINISH.
REQ-017 IDLE: start=1 SHALL latch count = min(word_count, MAX_WORDS), clear address and byte index to 0, go COLLECT; if latched count is 0, go FINISH instead.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 byte_ready SHALL be 1 only in COLLECT; a byte is accepted when byte_valid && byte_ready.
REQ-020 Byte assembly SHALL be little-endian: byte index 0 -> wdata[7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
REQ-021 On acceptance of byte index 3, FSM SHALL go WRITE next cycle; byte index SHALL wrap to 0.
REQ-022 byte_valid=0 in COLLECT SHALL hold all state; no timeout.
REQ-023 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr = current address, imem_wdata = assembled word.
REQ-024 After WRITE, address and written-word counter SHALL increment by 1; if written == latched count go FINISH, else COLLECT.
REQ-025 Write latency: imem_we SHALL assert exactly one cycle after the 4th byte is accepted.
REQ-026 Address SHALL never exceed MAX_WORDS-1; no wrap-around occurs because count is saturated.
REQ-027 FINISH SHALL last one cycle with done=1, then go IDLE.
REQ-028 busy SHALL be 1 in COLLECT, WRITE, FINISH; 0 in IDLE.
REQ-029 cpu_hold SHALL equal busy.
REQ-030 imem_we SHALL be 0 outside WRITE; imem_addr and imem_wdata SHALL hold last values outside WRITE.
REQ-031 word_count changes after start acceptance SHALL have no effect on the active session.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force IDLE, address 0, byte index 0, counters 0, imem_wdata 0.
REQ-033 Under reset, byte_ready, imem_we, busy, cpu_hold, done SHALL all be 0 and imem_addr SHALL be 0.
REQ-034 Reset mid-session SHALL discard any partial word; no imem_we SHALL issue for it.
REQ-035 Reset has priority over start and byte_valid in the same cycle.

Verification
REQ-036 start, word_count=1, bytes 93 02 00 00 back-to-back -> one imem_we, addr 0, wdata 0x00000293, done pulse one cycle after WRITE, busy low after done.
REQ-037 word_count=5, bytes of 0x00000293, 0x00128293, 0x00502023, 0x00002303, 0xFF5FF0EF with random byte_valid gaps -> five writes to addr 0..4 with those words, in order, one cycle each.
REQ-038 word_count=0 -> no imem_we, busy high one cycle (FINISH), done pulse, return to IDLE; byte_ready stays 0.
REQ-039 word_count=5000 -> session saturates at 4096 writes, last addr 0xFFF, then done.
REQ-040 rst_n=0 after 2 bytes of word 3 -> all outputs 0 next cycle, no write at addr 3; new start restarts at addr 0.
REQ-041 start pulsed while busy with word_count=7 -> ignored; session completes with original count.
